// File: rtl/histogram_register_file_if.sv
// Bus bundle for histogram_register_file: execute-stage control, addresses,
// operands and the combinational read-data return.
// The master drives the request side and the slave (the register file) drives RD.
interface histogram_register_file_if #(
    parameter int AW = 6,
    parameter int DW = 64
);
    logic          WE;
    logic          GET8;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] Rv;
    logic [DW-1:0] WD;
    logic [DW-1:0] RD;

    modport master (
        output WE, GET8, A1, A2, Rv, WD,
        input  RD
    );

    modport slave (
        input  WE, GET8, A1, A2, Rv, WD,
        output RD
    );
endinterface

// File: rtl/histogram_register_file.sv
// histogram_register_file: NREGS x 64-bit histogram bin storage.
// Normal mode: combinational read of reg[A1] and synchronous write of reg[A2] <= WD.
// Gather mode (GET8=1): the eight byte lanes of Rv each select a bin.
//   Each selected bin is returned saturated to 8 bits in its own lane of RD.
// Optional macro HIST_INC_EN: WE with GET8 becomes a scatter-increment.
//   Every lane adds one to its bin, and duplicate lanes accumulate.
//   Without the macro, WE with GET8 is an ordinary write of WD to reg[A2].
module histogram_register_file #(
    parameter int NREGS = 64,
    parameter int AW    = 6,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    histogram_register_file_if.slave   bus
);

    localparam int LANES = 8;

    logic [DW-1:0] regs_q   [NREGS];
    logic [DW-1:0] regs_d   [NREGS];
    logic [AW-1:0] lane_idx [LANES];
    logic [DW-1:0] rd_comb;
    logic          unused_rv_hi;

    // Saturate a bin count to one byte lane.
    function automatic logic [7:0] sat8(input logic [DW-1:0] v);
        return (|v[DW-1:8]) ? 8'hFF : v[7:0];
    endfunction

    // Slice Rv into per-lane bin indices. Lane bits above AW-1 only alias bins.
    always_comb begin
        unused_rv_hi = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i]  = bus.Rv[8*i +: AW];
            unused_rv_hi = unused_rv_hi ^ (^bus.Rv[8*i +: 8]);
        end
    end

    // Next register contents: a single write, or a scatter-increment when enabled.
    always_comb begin
`ifdef HIST_INC_EN
        logic [3:0] hits;
        hits = '0;
`endif
        regs_d = regs_q;
`ifdef HIST_INC_EN
        if (bus.WE && bus.GET8) begin
            // Count the lanes hitting each bin so that duplicate lanes add up in one edge.
            for (int b = 0; b < NREGS; b++) begin
                hits = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_idx[i] == AW'(b)) begin
                        hits = hits + 4'd1;
                    end
                end
                regs_d[b] = regs_q[b] + DW'(hits);
            end
        end else if (bus.WE) begin
            regs_d[bus.A2] = bus.WD;
        end
`else
        if (bus.WE) begin
            regs_d[bus.A2] = bus.WD;
        end
`endif
    end

    // Bin storage. The asynchronous clear wins over any write pending on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-latency read with no write bypass: a new value shows only after the edge.
    always_comb begin
        rd_comb = '0;
        if (!rst_n) begin
            rd_comb = '0;
        end else if (bus.GET8) begin
            for (int i = 0; i < LANES; i++) begin
                rd_comb[8*i +: 8] = sat8(regs_q[lane_idx[i]]);
            end
        end else begin
            rd_comb = regs_q[bus.A1];
        end
    end

    assign bus.RD = rd_comb;

endmodule

// File: tb/tb_histogram_register_file.sv
// Directed bench for histogram_register_file.
// A bin-array model predicts RD. A negedge process compares RD to the model every cycle.
// Hand-computed literal checks pin the model on the interesting cases.
module tb_histogram_register_file;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef logic [63:0] bins_t [64];
    bins_t mdl;

    histogram_register_file_if #(.AW(6), .DW(64)) bus ();

    histogram_register_file #(.NREGS(64), .AW(6), .DW(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HIST_INC_EN
    // Each lane adds one to the bin named by its low six bits.
    function automatic bins_t scatter(input bins_t m, input logic [63:0] rv);
        bins_t r;
        logic [5:0] b;
        r = m;
        for (int i = 0; i < 8; i++) begin
            b = rv[8*i +: 6];
            r[b] = r[b] + 64'd1;
        end
        return r;
    endfunction
`endif

    // Model of the bin storage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) mdl[k] <= 64'd0;
        end else begin
`ifdef HIST_INC_EN
            if (bus.WE && bus.GET8) mdl <= scatter(mdl, bus.Rv);
            else if (bus.WE) mdl[bus.A2] <= bus.WD;
`else
            if (bus.WE) mdl[bus.A2] <= bus.WD;
`endif
        end
    end

    // Expected RD from the model and the current inputs.
    function automatic logic [63:0] exp_rd();
        logic [63:0] r;
        logic [5:0]  b;
        r = 64'd0;
        if (!rst_n) return 64'd0;
        if (bus.GET8) begin
            for (int i = 0; i < 8; i++) begin
                b = bus.Rv[8*i +: 6];
                r[8*i +: 8] = (mdl[b] > 64'd255) ? 8'hFF : mdl[b][7:0];
            end
        end else begin
            r = mdl[bus.A1];
        end
        return r;
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [63:0] e;
        e = exp_rd();
        checks++;
        if (bus.RD !== e) begin
            errors++;
            $display("FAIL model_rd t=%0t got=%h want=%h", $time, bus.RD, e);
        end
    end

    task automatic lit(input string nm, input logic [63:0] want);
        #1;
        checks++;
        if (bus.RD !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, bus.RD, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [63:0] d);
        bus.GET8 = 1'b0;
        bus.WE   = 1'b1;
        bus.A2   = a;
        bus.WD   = d;
        tick();
        bus.WE   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.WE   = 1'b0;
        bus.GET8 = 1'b0;
        bus.A1   = '0;
        bus.A2   = '0;
        bus.Rv   = '0;
        bus.WD   = '0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_rd_low", 64'd0);
        rst_n = 1'b1;

        // Every register reads zero after reset.
        for (int a = 0; a < 64; a++) begin
            bus.A1 = 6'(a);
            lit("reset_clear", 64'd0);
            tick();
        end
        bus.GET8 = 1'b1;
        bus.Rv   = 64'hC0804000C0804000;
        lit("reset_gather", 64'd0);
        tick();

        // Normal write and read.
        write_reg(6'd2, 64'h00824000C0804000);
        bus.A1 = 6'd2;
        lit("wr_rd_a2", 64'h00824000C0804000);
        bus.A1 = 6'd3;
        lit("wr_rd_a3", 64'd0);
        tick();

        // Gather with saturation and aliasing of the upper lane bits.
        write_reg(6'd0, 64'h5);
        write_reg(6'd1, 64'h1FF);
        write_reg(6'd63, 64'hFF);
        bus.GET8 = 1'b1;
        bus.Rv   = 64'h3F3F01010000C040;
        lit("gather_sat", 64'hFFFFFFFF05050505);
        bus.Rv   = 64'h0000000000000200;
        lit("gather_big", 64'h050505050505FF05);
        tick();
        bus.GET8 = 1'b0;

        // Read during write to the same address has no bypass.
        bus.A1 = 6'd5;
        bus.A2 = 6'd5;
        bus.WD = 64'hAB;
        bus.WE = 1'b1;
        lit("raw_before", 64'd0);
        tick();
        lit("raw_after", 64'hAB);
        bus.WE = 1'b0;
        tick();

        // An asynchronous reset pulse between edges clears the bins at once.
        bus.A1 = 6'd5;
        rst_n  = 1'b0;
        lit("rst_pulse_rd", 64'd0);
        rst_n  = 1'b1;
        lit("rst_pulse_clear5", 64'd0);
        bus.A1 = 6'd2;
        lit("rst_pulse_clear2", 64'd0);
        tick();

        // WE together with GET8, held for two edges.
        bus.WE   = 1'b1;
        bus.GET8 = 1'b1;
        bus.Rv   = 64'hC0804000C0804000;
        bus.A2   = 6'd7;
        bus.WD   = 64'h1234;
        tick();
        tick();
        bus.WE = 1'b0;
`ifdef HIST_INC_EN
        lit("scatter_gather", 64'h1010101010101010);
        bus.GET8 = 1'b0;
        bus.A1   = 6'd0;
        lit("scatter_bin0", 64'd16);
        bus.A1   = 6'd7;
        lit("scatter_bin7", 64'd0);
`else
        lit("we_get8_gather", 64'd0);
        bus.GET8 = 1'b0;
        bus.A1   = 6'd0;
        lit("we_get8_bin0", 64'd0);
        bus.A1   = 6'd7;
        lit("we_get8_bin7", 64'h1234);
`endif
        tick();

        // Reset asserted mid-operation with a write pending.
        write_reg(6'd9, 64'h99);
        bus.A1 = 6'd9;
        lit("midop_pre", 64'h99);
        bus.A2 = 6'd9;
        bus.WD = 64'h55;
        bus.WE = 1'b1;
        rst_n  = 1'b0;
        lit("midop_rd_low", 64'd0);
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        rst_n  = 1'b1;
        lit("midop_no_write", 64'd0);
        tick();
        write_reg(6'd9, 64'h77);
        lit("post_reset_write", 64'h77);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
